// File: rtl/elevator_controller.sv
// -----------------------------------------------------------------------------
// elevator_controller
//
// Single-car elevator controller using a SCAN policy. It latches hall and car
// call buttons, keeps travelling in the current direction while calls remain
// ahead, then reverses. Internal counters time the floor-to-floor travel and
// the door dwell. The registered outputs drive the display adapter directly.
//
// Ports:
//   clock          in   sole clock, all state changes on the rising edge
//   reset_n        in   synchronous active-low reset
//   call_req       in   [NUM_FLOORS] call buttons, bit f = floor f (level or pulse)
//   current_floor  out  [3] registered floor index
//   direction      out  registered travel direction, 1 = up, 0 = down
//   open           out  registered door-open indicator
//   moving         out  registered, high exactly while the car is in MOVE
//   pending        out  [NUM_FLOORS] registered outstanding-call vector
// -----------------------------------------------------------------------------
module elevator_controller #(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [2:0]            current_floor,
    output logic                  direction,
    output logic                  open,
    output logic                  moving,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t                  state, next_state;
    logic [TW-1:0]           travel_cnt, travel_cnt_d;
    logic [DW-1:0]           door_cnt, door_cnt_d;
    logic [2:0]              floor_d;
    logic                    direction_d, open_d, moving_d;
    logic [NUM_FLOORS-1:0]   pending_d;
    logic [NUM_FLOORS-1:0]   req;
    logic [2:0]              arrive_floor;
    logic                    idle_ahead;

    // Helpers work on a 3-bit floor index so any legal NUM_FLOORS indexes safely.
    function automatic logic bit_at(input logic [NUM_FLOORS-1:0] r, input logic [2:0] f);
        bit_at = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (3'(i) == f) bit_at = r[i];
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] r, input logic [2:0] f);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (r[i] && (3'(i) > f)) any_above = 1'b1;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] r, input logic [2:0] f);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (r[i] && (3'(i) < f)) any_below = 1'b1;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [2:0] f);
        onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (3'(i) == f) onehot[i] = 1'b1;
    endfunction

    assign req          = pending | call_req;
    assign arrive_floor = direction ? current_floor + 3'd1 : current_floor - 3'd1;
    assign idle_ahead   = direction ? any_above(req, current_floor)
                                    : any_below(req, current_floor);

    // State and datapath registers.
    // NOTE: every register, including the call vector, is reset so a reset
    // mid-trip discards all outstanding calls and returns to floor 0 at once.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            current_floor <= 3'd0;
            direction     <= 1'b1;
            open          <= 1'b0;
            moving        <= 1'b0;
            pending       <= '0;
            travel_cnt    <= '0;
            door_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational processes.
            state         <= next_state;
            current_floor <= floor_d;
            direction     <= direction_d;
            open          <= open_d;
            moving        <= moving_d;
            pending       <= pending_d;
            travel_cnt    <= travel_cnt_d;
            door_cnt      <= door_cnt_d;
        end
    end

    // Next-state logic. Arrival decisions look at the floor being arrived at.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned
        // and no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bit_at(req, current_floor))
                    next_state = DOOR;
                else if (req != '0)
                    next_state = MOVE;
            end
            MOVE: begin
                if (travel_cnt == '0) begin
                    if (bit_at(req, arrive_floor))
                        next_state = DOOR;
                    else if (direction ? any_above(req, arrive_floor)
                                       : any_below(req, arrive_floor))
                        next_state = MOVE;
                    else
                        next_state = IDLE;
                end
            end
            DOOR: begin
                if (!bit_at(call_req, current_floor) && door_cnt == '0)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        floor_d      = current_floor;
        direction_d  = direction;
        pending_d    = req;
        travel_cnt_d = travel_cnt;
        door_cnt_d   = door_cnt;
        unique case (state)
            IDLE: begin
                if (next_state == DOOR) begin
                    pending_d  = req & ~onehot(current_floor);
                    door_cnt_d = DW'(DOOR_CYCLES - 1);
                end else if (next_state == MOVE) begin
                    travel_cnt_d = TW'(TRAVEL_CYCLES - 1);
                    // Nothing ahead means the only calls are behind: reverse.
                    if (!idle_ahead) direction_d = ~direction;
                end
            end
            MOVE: begin
                if (travel_cnt == '0) begin
                    floor_d = arrive_floor;
                    if (next_state == DOOR) begin
                        pending_d  = req & ~onehot(arrive_floor);
                        door_cnt_d = DW'(DOOR_CYCLES - 1);
                    end else if (next_state == MOVE) begin
                        travel_cnt_d = TW'(TRAVEL_CYCLES - 1);
                    end
                end else begin
                    travel_cnt_d = travel_cnt - TW'(1);
                end
            end
            DOOR: begin
                // A press for the open floor is absorbed and keeps the door open.
                pending_d = pending | (call_req & ~onehot(current_floor));
                if (bit_at(call_req, current_floor))
                    door_cnt_d = DW'(DOOR_CYCLES - 1);
                else if (door_cnt != '0)
                    door_cnt_d = door_cnt - DW'(1);
            end
            default: ;
        endcase
        open_d   = (next_state == DOOR);
        moving_d = (next_state == MOVE);
    end

    // The car must never step past either end of the shaft.
    always_ff @(posedge clock) begin
        if (reset_n && state == MOVE && travel_cnt == '0)
            assert (direction ? (current_floor != 3'(NUM_FLOORS - 1))
                              : (current_floor != 3'd0));
    end

endmodule

// File: tb/tb_elevator_controller.sv
// -----------------------------------------------------------------------------
// tb_elevator_controller
//
// Directed bench for elevator_controller with default parameters
// (8 floors, 4 travel cycles per floor, 6 door cycles). Inputs change 1 time
// unit after a rising edge and outputs are sampled at the same point, so
// "cycle N" is the interval that ends at the edge which samples the inputs.
// -----------------------------------------------------------------------------
module tb_elevator_controller;

    logic       clock;
    logic       reset_n;
    logic [7:0] call_req;
    logic [2:0] current_floor;
    logic       direction;
    logic       open;
    logic       moving;
    logic [7:0] pending;

    int errors = 0;
    int checks = 0;

    elevator_controller #(
        .NUM_FLOORS   (8),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (6)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .call_req     (call_req),
        .current_floor(current_floor),
        .direction    (direction),
        .open         (open),
        .moving       (moving),
        .pending      (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] f, input logic d,
                             input logic o, input logic m, input logic [7:0] p);
        check({tag, ".floor"},   32'(current_floor), 32'(f));
        check({tag, ".dir"},     32'(direction),     32'(d));
        check({tag, ".open"},    32'(open),          32'(o));
        check({tag, ".moving"},  32'(moving),        32'(m));
        check({tag, ".pending"}, 32'(pending),       32'(p));
    endtask

    initial begin
        reset_n  = 1'b0;
        call_req = 8'h00;

        // 1. Reset held for two edges, then idle with no calls.
        ticks(2);
        check_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        ticks(5);
        check_all("idle", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);

        // 2. Same-floor call at floor 0: cycle N.
        call_req = 8'h01;
        ticks(1);                                   // N+1
        call_req = 8'h00;
        check_all("same.n1", 3'd0, 1'b1, 1'b1, 1'b0, 8'h00);
        ticks(5);                                   // N+6
        check("same.n6.open", 32'(open), 32'd1);
        check("same.n6.pending", 32'(pending), 32'h00);
        ticks(1);                                   // N+7
        check("same.n7.open", 32'(open), 32'd0);
        check("same.n7.moving", 32'(moving), 32'd0);

        // 3. Travel up from floor 0 to floor 2: cycle M.
        call_req = 8'h04;
        ticks(1);                                   // M+1
        call_req = 8'h00;
        check_all("up.m1", 3'd0, 1'b1, 1'b0, 1'b1, 8'h04);
        ticks(3);                                   // M+4
        check("up.m4.floor", 32'(current_floor), 32'd0);
        ticks(1);                                   // M+5
        check("up.m5.floor", 32'(current_floor), 32'd1);
        check("up.m5.moving", 32'(moving), 32'd1);
        ticks(4);                                   // M+9
        check_all("up.m9", 3'd2, 1'b1, 1'b1, 1'b0, 8'h00);
        ticks(5);                                   // M+14
        check("up.m14.open", 32'(open), 32'd1);
        ticks(1);                                   // M+15
        check("up.m15.open", 32'(open), 32'd0);

        // 5. Door hold at floor 2: cycle P opens the door, re-press at counter=1.
        call_req = 8'h04;
        ticks(1);                                   // P+1, counter=5
        call_req = 8'h00;
        check("hold.p1.open", 32'(open), 32'd1);
        ticks(4);                                   // P+5, counter=1
        call_req = 8'h04;
        ticks(1);                                   // P+6
        call_req = 8'h00;
        check("hold.p6.pending", 32'(pending), 32'h00);
        ticks(1);                                   // P+7, would have closed
        check("hold.p7.open", 32'(open), 32'd1);
        ticks(4);                                   // P+11
        check("hold.p11.open", 32'(open), 32'd1);
        check("hold.p11.pending", 32'(pending), 32'h00);
        ticks(1);                                   // P+12
        check("hold.p12.open", 32'(open), 32'd0);

        // Move from floor 2 to floor 3 to set up the SCAN test: cycle Q.
        call_req = 8'h08;
        ticks(1);
        call_req = 8'h00;
        ticks(10);                                  // Q+11, idle at floor 3
        check_all("pos3", 3'd3, 1'b1, 1'b0, 1'b0, 8'h00);

        // 4. SCAN ordering: calls at 1 and 6 together from floor 3 going up: cycle R.
        call_req = 8'h42;
        ticks(1);                                   // R+1
        call_req = 8'h00;
        check_all("scan.r1", 3'd3, 1'b1, 1'b0, 1'b1, 8'h42);
        ticks(8);                                   // R+9, passing floor 5
        check_all("scan.r9", 3'd5, 1'b1, 1'b0, 1'b1, 8'h42);
        ticks(4);                                   // R+13, stop at 6
        check_all("scan.r13", 3'd6, 1'b1, 1'b1, 1'b0, 8'h02);
        ticks(6);                                   // R+19, idle at 6
        check_all("scan.r19", 3'd6, 1'b1, 1'b0, 1'b0, 8'h02);
        ticks(1);                                   // R+20, reversed
        check_all("scan.r20", 3'd6, 1'b0, 1'b0, 1'b1, 8'h02);
        ticks(19);                                  // R+39, at 2 still moving
        check_all("scan.r39", 3'd2, 1'b0, 1'b0, 1'b1, 8'h02);
        ticks(1);                                   // R+40, stop at 1
        check_all("scan.r40", 3'd1, 1'b0, 1'b1, 1'b0, 8'h00);
        ticks(6);                                   // R+46, idle at 1

        // 6. Reset mid-move between floors 4 and 5 with pending[7]: cycle S.
        call_req = 8'h80;
        ticks(1);                                   // S+1, reversed to up
        call_req = 8'h00;
        check_all("rst.s1", 3'd1, 1'b1, 1'b0, 1'b1, 8'h80);
        ticks(13);                                  // S+14, just left floor 4
        check_all("rst.s14", 3'd4, 1'b1, 1'b0, 1'b1, 8'h80);
        reset_n = 1'b0;
        ticks(1);
        reset_n = 1'b1;
        check_all("rst.after", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        ticks(3);
        check_all("rst.idle", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);

        // 7. Call for the floor being arrived at, on the arrival edge: cycle T.
        call_req = 8'h04;
        ticks(1);                                   // T+1
        call_req = 8'h00;
        ticks(3);                                   // T+4, counter=0
        call_req = 8'h02;
        ticks(1);                                   // T+5, stopped at 1
        call_req = 8'h00;
        check_all("arr.t5", 3'd1, 1'b1, 1'b1, 1'b0, 8'h04);
        ticks(11);                                  // T+16, reached 2
        check_all("arr.t16", 3'd2, 1'b1, 1'b1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Sequential car controller that feeds the display adapter directly: produces `current_floor`, `direction` and `open`, which the adapter turns into the floor digit, arrow segments and door LED.
- Latches hall/car call buttons, then runs a SCAN policy: keep travelling in the current direction while calls remain ahead, then reverse.
- Times floor-to-floor travel and door dwell with internal counters.

Parameters:
- NUM_FLOORS, 8: floors 0..NUM_FLOORS-1. Legal range 2..8, so floor index is always 3 bits.
- TRAVEL_CYCLES, 4: clock cycles spent in MOVE per one-floor step. Must be ≥1.
- DOOR_CYCLES, 6: cycles `open` is held high per stop. Must be ≥1.

Ports:
- clock, input, 1: sole clock; all state changes on rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- call_req, input, NUM_FLOORS: bit f = floor-f button press. Level or pulse; sampled every cycle.
- current_floor, output, 3: registered floor index; feeds display adapter.
- direction, output, 1: registered; 1 = up, 0 = down; feeds display adapter.
- open, output, 1: registered door-open indicator; feeds display adapter LED.
- moving, output, 1: registered; high exactly while state is MOVE.
- pending, output, NUM_FLOORS: registered outstanding-call vector.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, current_floor=0, direction=1, open=0, moving=0, pending=0, both counters=0. Reset mid-MOVE or mid-DOOR discards all calls and returns the car to floor 0 immediately; there is no travel animation.
- Effective request vector `req = pending | call_req`. pending[f] is set the cycle after call_req[f]=1, except as noted for DOOR below.
- "ahead" = any req bit strictly above current_floor when direction=1, or strictly below when direction=0. "behind" = the opposite side.
- IDLE:
  - If req[current_floor]: next state DOOR; open=1 next cycle; door counter loaded with DOOR_CYCLES-1; pending[current_floor] cleared.
  - Else if ahead: next state MOVE; direction unchanged; travel counter loaded with TRAVEL_CYCLES-1.
  - Else if behind: next state MOVE; direction inverted in the same edge.
  - Else: stay in IDLE.
- MOVE:
  - moving=1. Travel counter decrements each cycle.
  - On the cycle the counter reads 0 (arrival edge): current_floor += 1 if direction=1, else -= 1. Next state is evaluated in that same edge against the new floor:
    - req[new floor] → DOOR; pending bit cleared; open=1 on the edge where current_floor updates.
    - Else calls beyond the new floor in the same direction → MOVE, counter reloaded.
    - Else → IDLE.
- DOOR:
  - open=1 for exactly DOOR_CYCLES cycles; counter decrements each cycle; at 0 → IDLE, open=0.
  - call_req[current_floor] during DOOR is absorbed: it never sets pending and reloads the door counter to DOOR_CYCLES-1.
  - Other call bits latch normally.
- Boundaries:
  - Never step below floor 0 or above NUM_FLOORS-1. The ahead/behind logic guarantees this, and it is additionally asserted.
  - call_req bits ≥ NUM_FLOORS do not exist. Stale pending bits for nonexistent floors are impossible.
- Simultaneous events:
  - Calls above and below while IDLE: continue the current direction.
  - A call for the floor being arrived at on the arrival edge stops the car there.
  - A call for a floor just passed waits for the reverse sweep.
- Latency:
  - Call at current floor while IDLE (cycle N): open=1 from N+1 through N+DOOR_CYCLES; IDLE at N+DOOR_CYCLES+1.
  - Call k floors away while IDLE (cycle N): arrival and open=1 at N+1+k·TRAVEL_CYCLES.

Test Plan (defaults NUM_FLOORS=8, TRAVEL=4, DOOR=6):
1. Reset then idle: hold reset_n=0 for 2 cycles, release, no calls → floor=0, direction=1, open=0, moving=0, pending=0 indefinitely.
2. Same-floor call: at floor 0, pulse call_req[0] at cycle N → open=1 cycles N+1..N+6, pending[0] never set, open=0 and IDLE at N+7.
3. Travel up: at floor 0, pulse call_req[2] at N → moving=1 from N+1; floor=1 at N+5; floor=2 and open=1 at N+9; open falls at N+15.
4. SCAN ordering: at floor 3 (direction=1), pulse call_req[1] and call_req[6] together → car visits 6 first, then direction flips to 0 on leaving 6, stops at 1. pending returns to 0.
5. Door hold: during DOOR at floor 2, pulse call_req[2] at door-counter=1 → open held a further 6 cycles from that pulse; pending[2] stays 0.
6. Reset mid-move: between floors 4 and 5 with pending[7]=1, assert reset_n=0 for one edge → next cycle floor=0, moving=0, open=0, pending=0, direction=1.
